// File: rtl/tinyqv_data_arbiter.sv
// Round-robin arbiter sharing one data-bus slave port between requester A (CPU) and B (DMA/debug).
// Optional build macro TINYQV_ARB_TIMEOUT_EN adds a forced-completion timeout with a sticky flag.
module tinyqv_data_arbiter #(
  parameter int unsigned ADDR_W         = 28,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          FIRST_GRANT_B  = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic [ADDR_W-1:0] a_addr,
  input  logic [1:0]        a_write_n,
  input  logic [1:0]        a_read_n,
  input  logic [31:0]       a_data_out,
  output logic              a_ready,
  output logic [31:0]       a_data_in,

  input  logic [ADDR_W-1:0] b_addr,
  input  logic [1:0]        b_write_n,
  input  logic [1:0]        b_read_n,
  input  logic [31:0]       b_data_out,
  output logic              b_ready,
  output logic [31:0]       b_data_in,

  output logic [ADDR_W-1:0] s_addr,
  output logic [1:0]        s_write_n,
  output logic [1:0]        s_read_n,
  output logic [31:0]       s_data_out,
  input  logic              s_ready,
  input  logic [31:0]       s_data_in,

  output logic              grant_b,
  output logic              timeout_flag,
  input  logic              timeout_clr
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e state_q;
  logic   last_grant_b_q;  // 1 when B received the most recent grant
  logic   req_a, req_b, pick_b;
  logic   timeout_hit, done;
  logic [31:0] rdata;

  assign req_a = (a_write_n != 2'b11) || (a_read_n != 2'b11);
  assign req_b = (b_write_n != 2'b11) || (b_read_n != 2'b11);

  // On contention the requester that did not win last time gets the bus.
  assign pick_b = req_b && (!req_a || !last_grant_b_q);

`ifdef TINYQV_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        timeout_flag_q;

  assign timeout_hit = (state_q == StBusy) && !s_ready &&
                       (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_q      <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        tmo_cnt_q <= '0;
      end else if (!s_ready) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end
      if (timeout_hit) begin
        timeout_flag_q <= 1'b1;
      end else if (timeout_clr) begin
        timeout_flag_q <= 1'b0;
      end
    end
  end

  assign timeout_flag = timeout_flag_q;
`else
  logic        unused_clr;
  logic [15:0] unused_tmo;

  assign unused_clr   = timeout_clr;
  assign unused_tmo   = 16'(TIMEOUT_CYCLES);
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  assign done = (state_q == StBusy) && (s_ready || timeout_hit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      last_grant_b_q <= ~FIRST_GRANT_B;
      grant_b        <= 1'b0;
      s_addr         <= '0;
      s_write_n      <= 2'b11;
      s_read_n       <= 2'b11;
      s_data_out     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_a || req_b) begin
            state_q        <= StBusy;
            last_grant_b_q <= pick_b;
            grant_b        <= pick_b;
            s_addr         <= pick_b ? b_addr     : a_addr;
            s_data_out     <= pick_b ? b_data_out : a_data_out;
            s_write_n      <= pick_b ? b_write_n  : a_write_n;
            s_read_n       <= pick_b ? b_read_n   : a_read_n;
          end
        end
        StBusy: begin
          if (done) begin
            state_q   <= StIdle;
            grant_b   <= 1'b0;
            s_write_n <= 2'b11;
            s_read_n  <= 2'b11;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Slave data wins over a coincident timeout; a pure timeout returns all-ones.
  assign rdata = timeout_hit ? 32'hFFFF_FFFF : s_data_in;

  always_comb begin
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    a_data_in = '0;
    b_data_in = '0;
    if (state_q == StBusy) begin
      if (grant_b) begin
        b_ready   = done;
        b_data_in = rdata;
      end else begin
        a_ready   = done;
        a_data_in = rdata;
      end
    end
  end

endmodule
